data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/dmu_pkg.sv | 35 +++
 rtl/data_mem_unit_if.sv | 25 ++
 rtl/dmem_array.sv | 30 +++
 rtl/data_mem_unit.sv | 163 ++++++++++++++++
 tb/tb_data_mem_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmu_pkg.sv
// Shared types and constants for the data memory unit: RV32I width codes,
// FSM state encoding and request legality check.
package dmu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Misaligned halfword/word or a width code that has no meaning for this direction
    function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                         input logic [1:0] lo);
        logic ill;
        ill = 1'b1;
        case (f3)
            F3_B:    ill = 1'b0;
            F3_H:    ill = lo[0];
            F3_W:    ill = (lo != 2'b00);
            F3_BU:   ill = we;
            F3_HU:   ill = we | lo[0];
            default: ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Request/response bus between a load/store requester and data_mem_unit.
interface data_mem_unit_if #(
    parameter int unsigned size = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [size-1:0] req_addr;
    logic [size-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [size-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables; read is combinational
// and contents are deliberately not reset.
module dmem_array #(
    parameter int unsigned size  = 32,
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [size/8-1:0]        be_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [size-1:0]          wdata_i,
    output logic [size-1:0]          rdata_c_o
);
    localparam int unsigned NB = size / 8;

    logic [size-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_c_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_unit.sv
// Single-outstanding load/store unit: accepts one request, waits WAIT_STATES
// cycles, accesses the array on the edge entering RESP, then holds the response.
module data_mem_unit
    import dmu_pkg::*;
#(
    parameter int unsigned size        = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic            clk,
    input logic            reset,
    data_mem_unit_if.slave dmu_bus
);
    localparam int unsigned      IDX_W    = $clog2(DEPTH);
    localparam int unsigned      NB       = size / 8;
    localparam logic             NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [size-1:0]  addr_q;
    logic [size-1:0]  wdata_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic [size-1:0]  rsp_rdata_q;

    logic             accept_c;
    logic             enter_resp_c;
    logic             a_we_c;
    logic [2:0]       a_f3_c;
    logic [size-1:0]  a_addr_c;
    logic [size-1:0]  a_wdata_c;
    logic [1:0]       lo_c;
    logic             err_c;
    logic             arr_we_c;
    logic [NB-1:0]    be_c;
    logic [size-1:0]  wlane_c;
    logic [size-1:0]  rword_c;
    logic [size-1:0]  rshift_c;
    logic [size-1:0]  load_c;
    logic [size-1:0]  rsp_data_c;
    logic             unused_bits_c;

    // Live bus fields in IDLE cover the zero-wait path; otherwise use the latched request
    always_comb begin
        accept_c     = dmu_bus.req_valid && req_ready_q;
        a_we_c       = (state_q == IDLE) ? dmu_bus.req_we     : we_q;
        a_f3_c       = (state_q == IDLE) ? dmu_bus.req_funct3 : f3_q;
        a_addr_c     = (state_q == IDLE) ? dmu_bus.req_addr   : addr_q;
        a_wdata_c    = (state_q == IDLE) ? dmu_bus.req_wdata  : wdata_q;
        lo_c         = a_addr_c[1:0];
        err_c        = req_illegal(a_we_c, a_f3_c, lo_c);
        enter_resp_c = ((state_q == IDLE) && accept_c && NO_WAIT) ||
                       ((state_q == WAIT) && (cnt_q == '0));
        arr_we_c     = enter_resp_c && a_we_c && !err_c && reset;
    end

    // Store lane steering: replicate the right-aligned data, enable only target lanes
    always_comb begin
        be_c    = '0;
        wlane_c = a_wdata_c;
        case (a_f3_c)
            F3_B: begin
                be_c    = NB'(1) << lo_c;
                wlane_c = {NB{a_wdata_c[7:0]}};
            end
            F3_H: begin
                be_c    = NB'(3) << {lo_c[1], 1'b0};
                wlane_c = {(NB/2){a_wdata_c[15:0]}};
            end
            F3_W:    be_c = '1;
            default: be_c = '0;
        endcase
    end

    always_comb begin
        rshift_c = rword_c >> {lo_c, 3'b000};
        case (a_f3_c)
            F3_B:    load_c = {{(size-8){rshift_c[7]}}, rshift_c[7:0]};
            F3_H:    load_c = {{(size-16){rshift_c[15]}}, rshift_c[15:0]};
            F3_BU:   load_c = {{(size-8){1'b0}}, rshift_c[7:0]};
            F3_HU:   load_c = {{(size-16){1'b0}}, rshift_c[15:0]};
            default: load_c = rword_c;
        endcase
        rsp_data_c = (a_we_c || err_c) ? '0 : load_c;
    end

    assign unused_bits_c = ^{a_addr_c[size-1:IDX_W+2], rshift_c[size-1:16]};

    dmem_array #(
        .size  (size),
        .DEPTH (DEPTH)
    ) u_array (
        .clk       (clk),
        .we_i      (arr_we_c),
        .be_i      (be_c),
        .idx_i     (a_addr_c[IDX_W+1:2]),
        .wdata_i   (wlane_c),
        .rdata_c_o (rword_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        we_q        <= dmu_bus.req_we;
                        f3_q        <= dmu_bus.req_funct3;
                        addr_q      <= dmu_bus.req_addr;
                        wdata_q     <= dmu_bus.req_wdata;
                        cnt_q       <= CNT_INIT;
                        req_ready_q <= 1'b0;
                        state_q     <= NO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (dmu_bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
            if (enter_resp_c) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rsp_data_c;
                rsp_err_q   <= err_c;
            end
        end
    end

    assign dmu_bus.req_ready = req_ready_q;
    assign dmu_bus.rsp_valid = rsp_valid_q;
    assign dmu_bus.rsp_rdata = rsp_rdata_q;
    assign dmu_bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: a 1-wait-state instance for the vector table
// and stall/reset sequences, a 3-wait-state instance for reset-during-wait.
module tb_data_mem_unit;
    import dmu_pkg::*;

    logic clk = 1'b0;
    logic reset1, reset3;
    logic sel, rv, rwe, rrdy;
    logic [2:0]  rf3;
    logic [31:0] raddr, rwdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_unit_if #(.size(32)) if1 ();
    data_mem_unit_if #(.size(32)) if3 ();

    assign if1.req_valid  = rv & ~sel;
    assign if1.req_we     = rwe;
    assign if1.req_funct3 = rf3;
    assign if1.req_addr   = raddr;
    assign if1.req_wdata  = rwdata;
    assign if1.rsp_ready  = rrdy & ~sel;
    assign if3.req_valid  = rv & sel;
    assign if3.req_we     = rwe;
    assign if3.req_funct3 = rf3;
    assign if3.req_addr   = raddr;
    assign if3.req_wdata  = rwdata;
    assign if3.rsp_ready  = rrdy & sel;

    logic        s_ready, s_valid, s_err;
    logic [31:0] s_rdata;
    assign s_ready = sel ? if3.req_ready : if1.req_ready;
    assign s_valid = sel ? if3.rsp_valid : if1.rsp_valid;
    assign s_err   = sel ? if3.rsp_err   : if1.rsp_err;
    assign s_rdata = sel ? if3.rsp_rdata : if1.rsp_rdata;

    data_mem_unit #(.size(32), .DEPTH(256), .WAIT_STATES(1)) dut1 (
        .clk(clk), .reset(reset1), .dmu_bus(if1.slave)
    );
    data_mem_unit #(.size(32), .DEPTH(256), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset3), .dmu_bus(if3.slave)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic addv(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    // Issue one request, time the response (accept edge counts as 1), then complete it
    task automatic txn(input logic s, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        sel = s; rwe = we; rf3 = f3; raddr = addr; rwdata = wdata; rv = 1'b1; rrdy = 1'b0;
        chk("req_ready_idle", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        rv  = 1'b0;
        lat = 1;
        while (!s_valid && lat < 32) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = s_rdata;
        err   = s_err;
        @(negedge clk);
        rrdy = 1'b1;
        @(posedge clk); #1;
        rrdy = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        reset1 = 1'b0; reset3 = 1'b0;
        sel = 1'b0; rv = 1'b0; rwe = 1'b0; rrdy = 1'b0;
        rf3 = '0; raddr = '0; rwdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst1_ready", 32'(if1.req_ready), 32'd1);
        chk("rst1_valid", 32'(if1.rsp_valid), 32'd0);
        chk("rst1_rdata", if1.rsp_rdata, 32'd0);
        chk("rst1_err",   32'(if1.rsp_err),   32'd0);
        chk("rst3_ready", 32'(if3.req_ready), 32'd1);
        chk("rst3_valid", 32'(if3.rsp_valid), 32'd0);
        @(negedge clk);
        reset1 = 1'b1; reset3 = 1'b1;

        addv(1, F3_W,  32'h10,  32'hDEADBEEF, 32'h0,        0);
        addv(0, F3_W,  32'h10,  32'h0,        32'hDEADBEEF, 0);
        addv(0, F3_B,  32'h13,  32'h0,        32'hFFFFFFDE, 0);
        addv(0, F3_BU, 32'h13,  32'h0,        32'h000000DE, 0);
        addv(0, F3_H,  32'h12,  32'h0,        32'hFFFFDEAD, 0);
        addv(0, F3_HU, 32'h10,  32'h0,        32'h0000BEEF, 0);
        addv(1, F3_B,  32'h11,  32'h55,       32'h0,        0);
        addv(0, F3_W,  32'h10,  32'h0,        32'hDEAD55EF, 0);
        addv(0, F3_W,  32'h410, 32'h0,        32'hDEAD55EF, 0);
        addv(1, F3_W,  32'h12,  32'h12345678, 32'h0,        1);
        addv(0, F3_W,  32'h10,  32'h0,        32'hDEAD55EF, 0);
        addv(0, 3'b011, 32'h10, 32'h0,        32'h0,        1);
        addv(0, 3'b110, 32'h10, 32'h0,        32'h0,        1);
        addv(0, 3'b111, 32'h10, 32'h0,        32'h0,        1);
        addv(1, 3'b011, 32'h10, 32'h11111111, 32'h0,        1);
        addv(1, F3_BU, 32'h10,  32'h22,       32'h0,        1);
        addv(1, F3_H,  32'h13,  32'hFFFF,     32'h0,        1);
        addv(0, F3_HU, 32'h11,  32'h0,        32'h0,        1);
        addv(0, F3_W,  32'h11,  32'h0,        32'h0,        1);
        addv(0, F3_W,  32'h10,  32'h0,        32'hDEAD55EF, 0);
        addv(1, F3_W,  32'h14,  32'h0,        32'h0,        0);
        addv(1, F3_H,  32'h16,  32'hCAFE1234, 32'h0,        0);
        addv(0, F3_W,  32'h14,  32'h0,        32'h12340000, 0);
        addv(0, F3_HU, 32'h16,  32'h0,        32'h00001234, 0);
        addv(1, F3_H,  32'h14,  32'h8001,     32'h0,        0);
        addv(0, F3_H,  32'h14,  32'h0,        32'hFFFF8001, 0);
        addv(0, F3_B,  32'h15,  32'h0,        32'hFFFFFF80, 0);
        addv(0, F3_BU, 32'h15,  32'h0,        32'h00000080, 0);
        addv(1, F3_B,  32'h417, 32'hAB,       32'h0,        0);
        addv(0, F3_W,  32'h14,  32'h0,        32'hAB348001, 0);
        addv(0, F3_H,  32'h16,  32'h0,        32'hFFFFAB34, 0);

        foreach (vecs[i]) begin
            txn(1'b0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
        end

        // Stall in RESP with a competing store presented; it must be dropped
        @(negedge clk);
        sel = 1'b0; rwe = 1'b0; rf3 = F3_W; raddr = 32'h10; rv = 1'b1; rrdy = 1'b0;
        @(posedge clk); #1;
        rwe = 1'b1; rwdata = 32'h11111111;
        lat = 1;
        while (!s_valid && lat < 32) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("stall_latency", 32'(lat), 32'd2);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_valid", k), 32'(s_valid), 32'd1);
            chk($sformatf("stall%0d_rdata", k), s_rdata, 32'hDEAD55EF);
            chk($sformatf("stall%0d_ready", k), 32'(s_ready), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        rv = 1'b0; rrdy = 1'b1;
        @(posedge clk); #1;
        rrdy = 1'b0;
        chk("stall_done_valid", 32'(s_valid), 32'd0);
        chk("stall_done_ready", 32'(s_ready), 32'd1);
        txn(1'b0, 1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
        chk("stall_not_queued", rd, 32'hDEAD55EF);

        // Reset while an error response is held
        @(negedge clk);
        sel = 1'b0; rwe = 1'b0; rf3 = F3_H; raddr = 32'h11; rv = 1'b1; rrdy = 1'b0;
        @(posedge clk); #1;
        rv = 1'b0;
        @(posedge clk); #1;
        chk("rresp_err_before", 32'(s_err), 32'd1);
        chk("rresp_valid_before", 32'(s_valid), 32'd1);
        @(negedge clk);
        reset1 = 1'b0;
        @(posedge clk); #1;
        chk("rresp_valid", 32'(s_valid), 32'd0);
        chk("rresp_err", 32'(s_err), 32'd0);
        chk("rresp_rdata", s_rdata, 32'd0);
        chk("rresp_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        reset1 = 1'b1;
        txn(1'b0, 1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
        chk("rresp_array_kept", rd, 32'hDEAD55EF);

        // Three wait states: latency, then reset on the edge that would have written
        txn(1'b1, 1'b1, F3_W, 32'h20, 32'h01020304, rd, er, lat);
        chk("ws3_store_latency", 32'(lat), 32'd4);
        chk("ws3_store_err", 32'(er), 32'd0);
        @(negedge clk);
        sel = 1'b1; rwe = 1'b1; rf3 = F3_W; raddr = 32'h20; rwdata = 32'hA5A5A5A5;
        rv = 1'b1; rrdy = 1'b0;
        @(posedge clk); #1;
        rv = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("ws3_wait_valid", 32'(s_valid), 32'd0);
        chk("ws3_wait_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        reset3 = 1'b0;
        @(posedge clk); #1;
        chk("ws3_rst_valid", 32'(s_valid), 32'd0);
        chk("ws3_rst_rdata", s_rdata, 32'd0);
        chk("ws3_rst_err", 32'(s_err), 32'd0);
        chk("ws3_rst_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        reset3 = 1'b1;
        txn(1'b1, 1'b0, F3_W, 32'h20, 32'h0, rd, er, lat);
        chk("ws3_prior_contents", rd, 32'h01020304);
        chk("ws3_load_latency", 32'(lat), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
